// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU control path.
// Holds the datapath widths, the instruction field positions, the opcode
// values and the sequencer state encoding.
package cpu_pkg;

  localparam int CPU_DATA_W  = 8;
  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_INSTR_W = 16;

  // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JC   = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_regfile.sv
// 4x8 register file for the CPU.
// Ports:
//   clk, rst               clock, async active-high reset (clears all regs)
//   rd_a_sel_i/rd_a_data_o async read port A (operand a)
//   rd_b_sel_i/rd_b_data_o async read port B (operand b)
//   dbg_sel_i/dbg_data_o   async debug read port
//   wr_en_i/wr_sel_i/wr_data_i  synchronous write port
module cpu_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  rd_a_sel_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [SEL_W-1:0]  rd_b_sel_i,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic [SEL_W-1:0]  dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      regs_q[wr_sel_i] <= wr_data_i;
    end
  end

  assign rd_a_data_o = regs_q[rd_a_sel_i];
  assign rd_b_data_o = regs_q[rd_b_sel_i];
  assign dbg_data_o  = regs_q[dbg_sel_i];

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns PC, IR, carry/zero flags and the sticky illegal bit; the register file
// lives in cpu_regfile. Drives an external combinational ALU and reads an
// external asynchronous program ROM.
// Ports:
//   clk, rst             clock, async active-high reset
//   start                begin execution at PC=0 (honoured in IDLE/HALT only)
//   instr_addr/instr_data ROM address (= PC) and returned instruction word
//   alu_a/alu_b/alu_sel  ALU operands and operation select
//   alu_result/alu_carry ALU result and carry out
//   busy/halted          sequencer status
//   carry_flag/zero_flag registered ALU flags
//   illegal              sticky, set by an undefined opcode
//   dbg_sel/dbg_data     combinational register read for debug
// The sequencer state is visible on busy/halted; state_q is the single FSM
// register for anyone binding checkers inside the hierarchy.
module cpu_control_unit #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [15:0]       instr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              busy,
  output logic              halted,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              illegal,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  import cpu_pkg::*;

  state_e                   state_q;
  logic [ADDR_W-1:0]        pc_q;
  logic [CPU_INSTR_W-1:0]   ir_q;
  logic [DATA_W-1:0]        op_a_q, op_b_q, result_q;
  logic                     carry_q, zero_q, illegal_q;
  logic [2:0]               alu_sel_q;
  logic                     busy_q, halted_q;

  logic [3:0]               opcode;
  logic [1:0]               rd_sel, rs_sel;
  logic [7:0]               imm;
  logic [DATA_W-1:0]        rd_a_data, rd_b_data, wb_data;
  logic                     wb_en;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];
  assign rd_sel = ir_q[RD_MSB:RD_LSB];
  assign rs_sel = ir_q[RS_MSB:RS_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];

  // Only ALU/LDI/MOV ever reach WRITEBACK, so the state alone enables the write.
  assign wb_en = (state_q == ST_WRITEBACK);

  always_comb begin
    wb_data = op_b_q;  // MOV
    case (opcode)
      OP_ALU:  wb_data = result_q;
      OP_LDI:  wb_data = DATA_W'(imm);
      default: wb_data = op_b_q;
    endcase
  end

  cpu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(2)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rd_a_sel_i (rd_sel),
    .rd_a_data_o(rd_a_data),
    .rd_b_sel_i (rs_sel),
    .rd_b_data_o(rd_b_data),
    .dbg_sel_i  (dbg_sel),
    .dbg_data_o (dbg_data),
    .wr_en_i    (wb_en),
    .wr_sel_i   (rd_sel),
    .wr_data_i  (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      alu_sel_q <= 3'b000;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir_q    <= instr_data;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          // Operands are frozen here so a writeback to rd cannot disturb them.
          op_a_q    <= rd_a_data;
          op_b_q    <= rd_b_data;
          alu_sel_q <= (opcode == OP_ALU) ? imm[2:0] : 3'b000;
          state_q   <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          alu_sel_q <= 3'b000;
          state_q   <= ST_FETCH;
          case (opcode)
            OP_ALU: begin
              result_q <= alu_result;
              carry_q  <= alu_carry;
              zero_q   <= (alu_result == '0);
              state_q  <= ST_WRITEBACK;
            end
            OP_LDI, OP_MOV: state_q <= ST_WRITEBACK;
            OP_JMP:  pc_q <= ADDR_W'(imm);
            OP_JC:   if (carry_q) pc_q <= ADDR_W'(imm);
            OP_JZ:   if (zero_q)  pc_q <= ADDR_W'(imm);
            OP_NOP:  ;
            OP_HALT: begin
              state_q  <= ST_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end
            default: illegal_q <= 1'b1;
          endcase
        end
        ST_WRITEBACK: state_q <= ST_FETCH;
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_addr = pc_q;
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = alu_sel_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign illegal    = illegal_q;

endmodule
